// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl.
// The datapath side is master; the hazard controller is slave.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Operand identification from ID, EX, MEM and WB
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic             ex_use_rs1;
    logic             ex_use_rs2;
    logic [4:0]       ex_rdest;
    logic             ex_mem_read;
    logic [4:0]       mem_rdest;
    logic [4:0]       wb_rdest;
    logic             mem_reg_write;
    logic             wb_reg_write;
    logic             pc_sel;
    logic             dmem_req;
    logic             dmem_ready;

    // Pipeline control back to the datapath
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             err_timeout;
    logic [1:0]       state_o;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
        output ex_rdest, ex_mem_read,
        output mem_rdest, wb_rdest, mem_reg_write, wb_reg_write,
        output pc_sel, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush,
        input  forwardA, forwardB,
        input  stall_cnt, flush_cnt, err_timeout, state_o
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
        input  ex_rdest, ex_mem_read,
        input  mem_rdest, wb_rdest, mem_reg_write, wb_reg_write,
        input  pc_sel, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush,
        output forwardA, forwardB,
        output stall_cnt, flush_cnt, err_timeout, state_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, EX forwarding selects,
// stall/flush performance counters and a sticky data-memory timeout flag.
module hazard_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [15:0]      WAIT_MAX = 16'hFFFF;
    localparam logic [16:0]      WAIT_LIM = 17'(MAX_WAIT);

    state_t           state_reg;
    state_t           state_next;
    logic [15:0]      wait_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             err_reg;

    logic             mem_wait;
    logic             in_flush;
    logic             load_use;
    logic             freeze;
    logic             lu_stall;
    logic [4:0]       en_next;
    logic [2:0]       flush_next;
    logic             wait_limit;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign mem_wait = hz.dmem_req & ~hz.dmem_ready;
    assign in_flush = (state_reg == FLUSH);
    assign load_use = hz.ex_mem_read & (hz.ex_rdest != 5'd0) &
                      ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rdest)) |
                       (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rdest)));

    // The wait counter covers every frozen cycle, including the cycle that
    // first enters MEM_WAIT, so it tracks how long the pipeline is held.
    assign wait_limit = ({1'b0, wait_cnt_reg} + 17'd1) >= WAIT_LIM;

    // ------------------------------------------------------------------
    // Next state and pipeline control (wait > branch > load-use > normal)
    // ------------------------------------------------------------------
    always_comb begin
        state_next = RUN;
        en_next    = 5'b11111;
        flush_next = 3'b000;
        freeze     = 1'b0;
        lu_stall   = 1'b0;

        if (rst) begin
            en_next = 5'b00000;
        end else if (mem_wait) begin
            state_next = MEM_WAIT;
            en_next    = 5'b00000;
            freeze     = 1'b1;
        end else if (hz.pc_sel && !in_flush) begin
            // pc_sel is still held by EX/MEM after a wait, so this also
            // covers a branch that was pending through MEM_WAIT.
            state_next = FLUSH;
            flush_next = 3'b111;
        end else if (load_use && !in_flush) begin
            en_next    = 5'b00111;
            flush_next = 3'b010;
            lu_stall   = 1'b1;
        end
    end

    assign {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = en_next;
    assign {hz.ifid_flush, hz.idex_flush, hz.exmem_flush}               = flush_next;

    // ------------------------------------------------------------------
    // State, wait counter, timeout and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (freeze) begin
                if (wait_cnt_reg != WAIT_MAX)
                    wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end else begin
                wait_cnt_reg <= '0;
            end

            if (freeze && wait_limit)
                err_reg <= 1'b1;

            if ((freeze || lu_stall) && (stall_cnt_reg != CNT_MAX))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;

            // One FLUSH cycle follows every taken branch, so counting here
            // yields exactly one increment per flush event.
            if (in_flush && (flush_cnt_reg != CNT_MAX))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign hz.stall_cnt   = rst ? '0    : stall_cnt_reg;
    assign hz.flush_cnt   = rst ? '0    : flush_cnt_reg;
    assign hz.err_timeout = rst ? 1'b0  : err_reg;
    assign hz.state_o     = rst ? RUN   : state_reg;

    // ------------------------------------------------------------------
    // EX operand forwarding; index 0 is rs1 (forwardA), 1 is rs2 (forwardB)
    // ------------------------------------------------------------------
    logic [1:0][4:0] ex_src;
    logic [1:0]      ex_use;
    logic [1:0][1:0] fwd_sel;

    assign ex_src = {hz.ex_rs2, hz.ex_rs1};
    assign ex_use = {hz.ex_use_rs2, hz.ex_use_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_mem;
            logic hit_wb;

            assign hit_mem = ex_use[gi] & hz.mem_reg_write &
                             (hz.mem_rdest != 5'd0) & (hz.mem_rdest == ex_src[gi]);
            assign hit_wb  = ex_use[gi] & hz.wb_reg_write &
                             (hz.wb_rdest != 5'd0) & (hz.wb_rdest == ex_src[gi]);

            // The younger MEM result wins over WB.
            assign fwd_sel[gi] = rst     ? 2'b00 :
                                 hit_mem ? 2'b10 :
                                 hit_wb  ? 2'b01 : 2'b00;
        end
    endgenerate

    assign hz.forwardA = fwd_sel[0];
    assign hz.forwardB = fwd_sel[1];

endmodule
